// File: rtl/fmul_36bit_result_queue_pkg.sv
// Shared constants and types for the 36-bit floating multiplier result path.
package fmul36_pkg;

   localparam int FMUL36_W = 36;
   localparam int EXP_W    = 11;
   localparam int FRACT_W  = 24;

   localparam logic [EXP_W-1:0] EXP_MAX = 11'h7FF;

   // Bit positions inside the class vector
   localparam int CLS_ZERO   = 0;
   localparam int CLS_DENORM = 1;
   localparam int CLS_INF    = 2;
   localparam int CLS_NAN    = 3;
   localparam int CLS_W      = 4;

   typedef logic [CLS_W-1:0] fmul36_class_t;

endpackage

// File: rtl/fmul_36bit_result_queue_if.sv
// Handshake and status bundle between the multiplier, the result queue and its consumer.
interface fmul_36bit_result_queue_if
   import fmul36_pkg::*;
#(
   parameter int DEPTH_N = 2
);

   logic                  iDATA_VALID;
   logic                  oDATA_BUSY;
   logic [FMUL36_W-1:0]   iDATA;
   logic                  oDATA_VALID;
   logic                  iDATA_BUSY;
   logic [FMUL36_W-1:0]   oDATA;
   fmul36_class_t         oDATA_CLASS;
   logic [DEPTH_N:0]      oCOUNT;
   logic                  iSTICKY_CLEAR;
   fmul36_class_t         oSTICKY;

   // Queue side
   modport slave (
      input  iDATA_VALID, iDATA, iDATA_BUSY, iSTICKY_CLEAR,
      output oDATA_BUSY, oDATA_VALID, oDATA, oDATA_CLASS, oCOUNT, oSTICKY
   );

   // Producer/consumer side
   modport master (
      output iDATA_VALID, iDATA, iDATA_BUSY, iSTICKY_CLEAR,
      input  oDATA_BUSY, oDATA_VALID, oDATA, oDATA_CLASS, oCOUNT, oSTICKY
   );

endinterface

// File: rtl/fmul_36bit_classify.sv
// Combinational zero/denormal/inf/NaN classifier for a 36-bit float word.
module fmul_36bit_classify
   import fmul36_pkg::*;
(
   input  logic [FMUL36_W-1:0] word,
   output fmul36_class_t       cls
);

   logic [FMUL36_W-1:0] abs_word;
   logic [EXP_W-1:0]    exp_f;
   logic [FRACT_W-1:0]  fract_f;

   // Sign is masked off first so zero detection covers the whole magnitude
   always_comb begin
      abs_word               = word;
      abs_word[FMUL36_W-1]   = 1'b0;
      exp_f                  = abs_word[FMUL36_W-2 -: EXP_W];
      fract_f                = abs_word[FRACT_W-1:0];
      cls                    = '0;
      cls[CLS_ZERO]          = (abs_word == '0);
      cls[CLS_DENORM]        = (exp_f == '0) && (fract_f != '0);
      cls[CLS_INF]           = (exp_f == EXP_MAX) && (fract_f == '0);
      cls[CLS_NAN]           = (exp_f == EXP_MAX) && (fract_f != '0);
   end

endmodule

// File: rtl/fmul_36bit_result_queue.sv
// FWFT result queue with per-entry class tags and sticky exception flags.
module fmul_36bit_result_queue
   import fmul36_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int DEPTH_N = 2
)(
   input  logic                       iCLOCK,
   input  logic                       iRESET_SYNC,
   fmul_36bit_result_queue_if.slave   bus
);

   logic [FMUL36_W-1:0] mem     [DEPTH];
   fmul36_class_t       cls_mem [DEPTH];
   logic [DEPTH_N-1:0]  wptr;
   logic [DEPTH_N-1:0]  rptr;
   logic [DEPTH_N:0]    count;
   fmul36_class_t       sticky;
   fmul36_class_t       in_cls;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;

   fmul_36bit_classify u_classify (
      .word (bus.iDATA),
      .cls  (in_cls)
   );

   // Handshake decode from the registered occupancy only (no same-cycle look-ahead)
   always_comb begin
      full  = (count == (DEPTH_N+1)'(DEPTH));
      empty = (count == '0);
      push  = bus.iDATA_VALID && !full;
      pop   = !empty && !bus.iDATA_BUSY;
   end

   // Entry storage; contents need no reset
   always_ff @(posedge iCLOCK) begin
      if (push && !iRESET_SYNC) begin
         mem[wptr]     <= bus.iDATA;
         cls_mem[wptr] <= in_cls;
      end
   end

   // Pointers, occupancy and sticky flags
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         wptr   <= '0;
         rptr   <= '0;
         count  <= '0;
         sticky <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A clear drops old flags but keeps the class of a same-cycle push
         sticky <= (bus.iSTICKY_CLEAR ? '0 : sticky) | (push ? in_cls : '0);
      end
   end

   assign bus.oDATA_BUSY  = full;
   assign bus.oDATA_VALID = !empty;
   assign bus.oDATA       = empty ? '0 : mem[rptr];
   assign bus.oDATA_CLASS = empty ? '0 : cls_mem[rptr];
   assign bus.oCOUNT      = count;
   assign bus.oSTICKY     = sticky;

endmodule

// File: tb/tb_fmul_36bit_result_queue.sv
// Directed plus random bench for the multiplier result queue, checked against a queue model.
module tb_fmul_36bit_result_queue;

   localparam int DEPTH   = 4;
   localparam int DEPTH_N = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fmul_36bit_result_queue_if #(.DEPTH_N(DEPTH_N)) bus ();

   fmul_36bit_result_queue #(.DEPTH(DEPTH), .DEPTH_N(DEPTH_N)) dut (
      .iCLOCK      (clk),
      .iRESET_SYNC (rst),
      .bus         (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [35:0] mq[$];
   logic [3:0]  m_sticky;
   logic [35:0] words[5];
   logic [3:0]  exp_cls[3];

   function automatic logic [3:0] ref_class(input logic [35:0] w);
      int e;
      int f;
      e = int'(w[34:24]);
      f = int'(w[23:0]);
      return {(e == 2047 && f != 0), (e == 2047 && f == 0), (e == 0 && f != 0), (e == 0 && f == 0)};
   endfunction

   function automatic logic [35:0] rand_normal();
      logic [35:0] w;
      w[35]    = 1'($urandom % 2);
      w[34:24] = 11'($urandom_range(1, 2046));
      w[23:0]  = 24'($urandom);
      return w;
   endfunction

   function automatic logic [35:0] rand_any();
      logic [35:0] w;
      w = rand_normal();
      case ($urandom_range(0, 5))
         0: w[34:0] = '0;
         1: begin w[34:24] = '0;      w[23:0] = 24'($urandom_range(1, 24'hFFFFFF)); end
         2: begin w[34:24] = 11'h7FF; w[23:0] = '0; end
         3: begin w[34:24] = 11'h7FF; w[23:0] = 24'($urandom_range(1, 24'hFFFFFF)); end
         default: ;
      endcase
      return w;
   endfunction

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string where);
      logic [35:0] head;
      logic [3:0]  hcls;
      head = (mq.size() != 0) ? mq[0] : 36'h0;
      hcls = (mq.size() != 0) ? ref_class(mq[0]) : 4'h0;
      chk({where, " valid"},  36'(bus.oDATA_VALID), 36'(mq.size() != 0));
      chk({where, " busy"},   36'(bus.oDATA_BUSY),  36'(mq.size() == DEPTH));
      chk({where, " count"},  36'(bus.oCOUNT),      36'(mq.size()));
      chk({where, " data"},   bus.oDATA,            head);
      chk({where, " class"},  36'(bus.oDATA_CLASS), 36'(hcls));
      chk({where, " sticky"}, 36'(bus.oSTICKY),     36'(m_sticky));
   endtask

   // Drive one cycle of inputs, advance the model across the edge, sample 1 ns later
   task automatic tick(input logic v, input logic [35:0] d, input logic b, input logic c, input logic r);
      logic do_push;
      logic do_pop;
      do_push = v && (mq.size() < DEPTH) && !r;
      do_pop  = (mq.size() > 0) && !b && !r;
      bus.iDATA_VALID   = v;
      bus.iDATA         = d;
      bus.iDATA_BUSY    = b;
      bus.iSTICKY_CLEAR = c;
      rst               = r;
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_sticky = 4'h0;
      end else begin
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back(d);
         m_sticky = (c ? 4'h0 : m_sticky) | (do_push ? ref_class(d) : 4'h0);
      end
      #1;
   endtask

   task automatic drain(input string where);
      for (int k = 0; k < 12 && mq.size() > 0; k++) begin
         tick(1'b0, 36'h0, 1'b0, 1'b0, 1'b0);
         check_state(where);
      end
      chk({where, " drained"}, 36'(bus.oCOUNT), 36'h0);
   endtask

   initial begin
      bus.iDATA_VALID   = 1'b0;
      bus.iDATA         = '0;
      bus.iDATA_BUSY    = 1'b0;
      bus.iSTICKY_CLEAR = 1'b0;
      rst               = 1'b1;
      m_sticky          = 4'h0;

      // Reset state
      tick(1'b0, 36'h0, 1'b0, 1'b0, 1'b1);
      check_state("reset");

      // Single word through an empty queue
      tick(1'b1, 36'h3FF000000, 1'b0, 1'b0, 1'b0);
      check_state("single push");
      chk("single data", bus.oDATA, 36'h3FF000000);
      tick(1'b0, 36'h0, 1'b0, 1'b0, 1'b0);
      check_state("single pop");
      chk("single empty", 36'(bus.oDATA_VALID), 36'h0);

      // Fill while stalled; fifth word is refused
      for (int i = 0; i < 5; i++) words[i] = rand_normal();
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, words[i], 1'b1, 1'b0, 1'b0);
         check_state("fill");
      end
      chk("full busy", 36'(bus.oDATA_BUSY), 36'h1);
      chk("full count", 36'(bus.oCOUNT), 36'h4);
      chk("full head", bus.oDATA, words[0]);

      // Release the stall; upstream holds word 4 until taken
      for (int k = 0; k < 8; k++) begin
         logic taken;
         taken = (mq.size() < DEPTH);
         tick(1'b1, words[4], 1'b0, 1'b0, 1'b0);
         check_state("release");
         if (taken) break;
      end
      drain("drain fill");

      // Class tagging and sticky accumulation
      exp_cls[0] = 4'b0100;
      exp_cls[1] = 4'b1000;
      exp_cls[2] = 4'b0001;
      tick(1'b1, 36'h7FF000000, 1'b1, 1'b1, 1'b0);
      check_state("cls inf");
      tick(1'b1, 36'h7FF800000, 1'b1, 1'b0, 1'b0);
      check_state("cls nan");
      tick(1'b1, 36'h800000000, 1'b1, 1'b0, 1'b0);
      check_state("cls negzero");
      chk("cls sticky", 36'(bus.oSTICKY), 36'(4'b1101));
      for (int i = 0; i < 3; i++) begin
         chk("cls head", 36'(bus.oDATA_CLASS), 36'(exp_cls[i]));
         tick(1'b0, 36'h0, 1'b0, 1'b0, 1'b0);
         check_state("cls pop");
      end

      // Simultaneous push and pop at occupancy 2, across the pointer wrap
      tick(1'b1, rand_normal(), 1'b1, 1'b0, 1'b0);
      tick(1'b1, rand_normal(), 1'b1, 1'b0, 1'b0);
      check_state("pp fill");
      for (int i = 0; i < 6; i++) begin
         tick(1'b1, rand_any(), 1'b0, 1'b0, 1'b0);
         check_state("pp");
         chk("pp count", 36'(bus.oCOUNT), 36'h2);
      end

      // Random traffic
      for (int i = 0; i < 20; i++) begin
         tick(1'($urandom % 2), rand_any(), 1'($urandom % 2), 1'($urandom_range(0, 7) == 0), 1'b0);
         check_state("random");
      end
      drain("drain random");

      // Clear coinciding with a push keeps only the new class
      tick(1'b1, 36'h7FF800000, 1'b1, 1'b1, 1'b0);
      check_state("sticky nan");
      chk("sticky nan only", 36'(bus.oSTICKY), 36'(4'b1000));
      tick(1'b1, 36'h000000001, 1'b1, 1'b1, 1'b0);
      check_state("sticky clear push");
      chk("sticky denorm only", 36'(bus.oSTICKY), 36'(4'b0010));

      // Reset mid-operation with occupancy 3; push in the reset cycle is dropped
      tick(1'b1, rand_normal(), 1'b1, 1'b0, 1'b0);
      check_state("pre reset");
      chk("pre reset count", 36'(bus.oCOUNT), 36'h3);
      tick(1'b1, 36'h3FF000000, 1'b0, 1'b0, 1'b1);
      check_state("mid reset");
      chk("rst count", 36'(bus.oCOUNT), 36'h0);
      chk("rst valid", 36'(bus.oDATA_VALID), 36'h0);
      chk("rst sticky", 36'(bus.oSTICKY), 36'h0);
      chk("rst busy", 36'(bus.oDATA_BUSY), 36'h0);
      tick(1'b0, 36'h0, 1'b0, 1'b0, 1'b0);
      check_state("post reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
